// File: rtl/core_type.sv
// Types and constants shared by the core's memory-side blocks.
// The data-memory controller FSM states and the store-mask encodings it decodes.
package core_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_DONE = 2'd2
    } dmem_state_t;

    localparam logic [3:0] DM_MASK_WORD = 4'b1111;
    localparam logic [3:0] DM_MASK_HALF = 4'b0011;

endpackage

// File: rtl/dmem_ctrl_byte_array.sv
// Byte-wide RAM with four write lanes and a four-byte combinational read.
// Lane k addresses byte i_addr+k; the index wraps within the array and has no reset.
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 4096,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [7:0] r_mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            o_rdata[8*k +: 8] = r_mem[i_addr + AW'(k)];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the core's load/store port: wait-stated local RAM,
// range/alignment fault detection and completed-access counters.
module dmem_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH_BYTES  = 4096,
    parameter int          WAIT_STATES  = 0,
    parameter int          MISALIGN_ERR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_mem,
    input  logic        wmem_o,
    input  logic [3:0]  wmask,
    input  logic [31:0] addr_o,
    input  logic [31:0] data_o,
    output logic [31:0] data_i,
    output logic        data_stall,
    output logic        data_err,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt,
    output dmem_state_t o_dbg_state
);

    localparam int         AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    dmem_state_t r_state;
    logic [3:0]  r_wcnt;
    logic        r_we;
    logic [3:0]  r_wmask;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data_i;
    logic        r_err;
    logic [31:0] r_ld_cnt;
    logic [31:0] r_st_cnt;

    logic        w_live;
    logic        w_we;
    logic [3:0]  w_wmask;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_off;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_err;
    logic        w_commit;
    logic [3:0]  w_lane_we;
    logic [31:0] w_rdata;

    // With zero wait states the commit edge is the same edge that samples the
    // request, so the decode must look at the live fields instead of the latch.
    assign w_live  = (r_state == DM_IDLE);
    assign w_we    = w_live ? wmem_o : r_we;
    assign w_wmask = w_live ? wmask  : r_wmask;
    assign w_addr  = w_live ? addr_o : r_addr;
    assign w_wdata = w_live ? data_o : r_wdata;
    assign w_off   = w_addr - BASE_ADDR;

    always_comb begin
        w_range_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((!w_we || w_wmask[k]) &&
                (({1'b0, w_off} + 33'(k)) >= 33'(DEPTH_BYTES))) begin
                w_range_err = 1'b1;
            end
        end
    end

    assign w_align_err = (MISALIGN_ERR != 0) &&
        (w_we ? (((w_wmask == DM_MASK_WORD) && (w_addr[1:0] != 2'b00)) ||
                 ((w_wmask == DM_MASK_HALF) && w_addr[0]))
              : (w_addr[1:0] != 2'b00));

    assign w_err    = w_range_err | w_align_err;
    assign w_commit = reset &&
        (((r_state == DM_IDLE) && req_mem && (WS == 4'd0)) ||
         ((r_state == DM_BUSY) && (r_wcnt == 4'd0)));
    assign w_lane_we = (w_commit && w_we && !w_err) ? w_wmask : 4'b0000;

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_off[AW-1:0]),
        .i_we    (w_lane_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= DM_IDLE;
            r_wcnt   <= 4'd0;
            r_we     <= 1'b0;
            r_wmask  <= 4'b0000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_data_i <= 32'd0;
            r_err    <= 1'b0;
            r_ld_cnt <= 32'd0;
            r_st_cnt <= 32'd0;
        end else begin
            r_data_i <= 32'd0;
            r_err    <= 1'b0;
            case (r_state)
                DM_IDLE: begin
                    if (req_mem) begin
                        r_we    <= wmem_o;
                        r_wmask <= wmask;
                        r_addr  <= addr_o;
                        r_wdata <= data_o;
                        if (WS == 4'd0) begin
                            r_state <= DM_DONE;
                        end else begin
                            r_state <= DM_BUSY;
                            r_wcnt  <= WS - 4'd1;
                        end
                    end
                end
                DM_BUSY: begin
                    if (r_wcnt == 4'd0) r_state <= DM_DONE;
                    else                r_wcnt  <= r_wcnt - 4'd1;
                end
                default: r_state <= DM_IDLE;
            endcase
            if (w_commit) begin
                r_err <= w_err;
                if (!w_err && !w_we) r_data_i <= w_rdata;
                if (!w_err) begin
                    if (w_we) r_st_cnt <= r_st_cnt + 32'd1;
                    else      r_ld_cnt <= r_ld_cnt + 32'd1;
                end
            end
        end
    end

    assign data_stall  = req_mem & (r_state != DM_DONE) & reset;
    assign data_i      = r_data_i;
    assign data_err    = r_err;
    assign ld_cnt      = r_ld_cnt;
    assign st_cnt      = r_st_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 has no wait states and no alignment
// check, instance 1 has three wait states with alignment faults enabled.
module tb_dmem_ctrl;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  wm    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        stall [2];
    logic        err   [2];
    logic [31:0] ldc   [2];
    logic [31:0] stc   [2];
    dmem_state_t dbg   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    int          stalls;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    dmem_ctrl #(.BASE_ADDR(32'h0), .DEPTH_BYTES(4096), .WAIT_STATES(0), .MISALIGN_ERR(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .req_mem(req[0]), .wmem_o(we[0]), .wmask(wm[0]),
        .addr_o(addr[0]), .data_o(wdat[0]), .data_i(rdat[0]), .data_stall(stall[0]),
        .data_err(err[0]), .ld_cnt(ldc[0]), .st_cnt(stc[0]), .o_dbg_state(dbg[0]));

    dmem_ctrl #(.BASE_ADDR(32'h0), .DEPTH_BYTES(4096), .WAIT_STATES(3), .MISALIGN_ERR(1)) dut1 (
        .clk(clk), .reset(rst_n[1]), .req_mem(req[1]), .wmem_o(we[1]), .wmask(wm[1]),
        .addr_o(addr[1]), .data_o(wdat[1]), .data_i(rdat[1]), .data_stall(stall[1]),
        .data_err(err[1]), .ld_cnt(ldc[1]), .st_cnt(stc[1]), .o_dbg_state(dbg[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Holds the request until the controller stops stalling, then samples the DONE cycle.
    task automatic access(input int d, input logic w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] dat,
                          output int n_st, output logic [31:0] o_rd, output logic o_er);
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; wm[d] = m; addr[d] = a; wdat[d] = dat;
        n_st = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall[d]) n_st++;
            else break;
        end
        o_rd = rdat[d];
        o_er = err[d];
        @(posedge clk); #1;
        req[d] = 1'b0;
        @(negedge clk);
        chk("post_done_data_zero", rdat[d], 32'h0);
        chk("post_done_err_zero", {31'd0, err[d]}, 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
            wm[d] = 4'b0; addr[d] = 32'h0; wdat[d] = 32'h0;
        end
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_forced_low", {31'd0, stall[0]}, 32'd0);
        chk("rst_data_i", rdat[0], 32'h0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        chk("rst_ld_cnt", ldc[0], 32'd0);
        chk("rst_st_cnt", stc[0], 32'd0);
        chk("rst_state", {30'd0, dbg[0]}, {30'd0, DM_IDLE});
        @(posedge clk); #1;
        req[0] = 1'b0; rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Basic word store then load, zero wait states
        access(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, stalls, rd, er);
        chk("t1_st_stalls", stalls, 1);
        chk("t1_st_err", {31'd0, er}, 32'd0);
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, stalls, rd, er);
        chk("t1_ld_stalls", stalls, 1);
        chk("t1_ld_data", rd, 32'hDEADBEEF);
        chk("t1_st_cnt", stc[0], 32'd1);
        chk("t1_ld_cnt", ldc[0], 32'd1);

        // Byte and half lanes
        access(0, 1'b1, 4'b0001, 32'h13, 32'h000000AA, stalls, rd, er);
        access(0, 1'b1, 4'b0011, 32'h10, 32'h00005566, stalls, rd, er);
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, stalls, rd, er);
        chk("t3_lane_merge", rd, 32'hAAAD5566);
        chk("t3_st_cnt", stc[0], 32'd3);

        // Range checks at the top of the array
        access(0, 1'b0, 4'b0000, 32'd4094, 32'h0, stalls, rd, er);
        chk("t4_ld_oob_err", {31'd0, er}, 32'd1);
        chk("t4_ld_oob_data", rd, 32'h0);
        chk("t4_ld_cnt_hold", ldc[0], 32'd2);
        access(0, 1'b1, 4'b0001, 32'd4095, 32'h00000077, stalls, rd, er);
        chk("t4_st_last_byte_err", {31'd0, er}, 32'd0);
        chk("t4_st_cnt", stc[0], 32'd4);
        access(0, 1'b0, 4'b0000, 32'd4092, 32'h0, stalls, rd, er);
        chk("t4_ld_top_err", {31'd0, er}, 32'd0);
        chk("t4_ld_top_byte", {24'd0, rd[31:24]}, 32'h77);
        access(0, 1'b1, 4'b0001, 32'd4096, 32'h00000011, stalls, rd, er);
        chk("t4_st_past_end_err", {31'd0, er}, 32'd1);
        chk("t4_st_cnt_hold", stc[0], 32'd4);
        access(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, stalls, rd, er);
        chk("t4_empty_mask_err", {31'd0, er}, 32'd0);
        chk("t4_empty_mask_cnt", stc[0], 32'd5);

        // Misaligned word store accepted when alignment checking is off
        access(0, 1'b1, 4'b1111, 32'h12, 32'h11223344, stalls, rd, er);
        chk("t5_noalign_err", {31'd0, er}, 32'd0);
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, stalls, rd, er);
        chk("t5_noalign_data", rd, 32'h33445566);

        // Three wait states
        access(1, 1'b1, 4'b1111, 32'h20, 32'h12345678, stalls, rd, er);
        chk("t2_st_stalls", stalls, 4);
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall[1]) stalls++;
            else break;
        end
        chk("t2_ld_stalls", stalls, 4);
        chk("t2_done_state", {30'd0, dbg[1]}, {30'd0, DM_DONE});
        chk("t2_ld_data", rdat[1], 32'h12345678);
        chk("t2_ld_err", {31'd0, err[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;

        // Alignment faults enabled
        access(1, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, stalls, rd, er);
        access(1, 1'b1, 4'b1111, 32'h12, 32'h01020304, stalls, rd, er);
        chk("t5_misalign_word_err", {31'd0, er}, 32'd1);
        access(1, 1'b1, 4'b0011, 32'h11, 32'h0000ABCD, stalls, rd, er);
        chk("t5_misalign_half_err", {31'd0, er}, 32'd1);
        access(1, 1'b0, 4'b0000, 32'h12, 32'h0, stalls, rd, er);
        chk("t5_misalign_ld_err", {31'd0, er}, 32'd1);
        access(1, 1'b0, 4'b0000, 32'h10, 32'h0, stalls, rd, er);
        chk("t5_mem_unchanged", rd, 32'hDEADBEEF);
        chk("t5_st_cnt", stc[1], 32'd2);
        chk("t5_ld_cnt", ldc[1], 32'd2);

        // Dropping req and changing fields during BUSY must not affect the access
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; wm[1] = 4'b1111; addr[1] = 32'h50; wdat[1] = 32'h600DCAFE;
        @(posedge clk); #1;
        req[1] = 1'b0; we[1] = 1'b0; wm[1] = 4'b0000; addr[1] = 32'h0; wdat[1] = 32'h0;
        repeat (5) @(posedge clk);
        access(1, 1'b0, 4'b0000, 32'h50, 32'h0, stalls, rd, er);
        chk("busy_req_drop_data", rd, 32'h600DCAFE);

        // Reset during the second BUSY cycle drops the store
        access(1, 1'b1, 4'b1111, 32'h40, 32'hCAFEF00D, stalls, rd, er);
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; wm[1] = 4'b1111; addr[1] = 32'h40; wdat[1] = 32'h0BADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_busy", {30'd0, dbg[1]}, {30'd0, DM_BUSY});
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("t6_stall_forced_low", {31'd0, stall[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("t6_ld_cnt_clear", ldc[1], 32'd0);
        chk("t6_st_cnt_clear", stc[1], 32'd0);
        chk("t6_state_idle", {30'd0, dbg[1]}, {30'd0, DM_IDLE});
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        access(1, 1'b0, 4'b0000, 32'h40, 32'h0, stalls, rd, er);
        chk("t6_old_data", rd, 32'hCAFEF00D);
        chk("t6_ld_cnt_after", ldc[1], 32'd1);
        chk("t6_st_cnt_after", stc[1], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
